// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with valid/ready handshake, iterative shifts and optional multiply
//
// Purpose:
//   Sequential replacement for the CPU's combinational ALU. One op is accepted in IDLE and
//   worked on in BUSY (or MUL). The result and Z/N/V/C/err flags are registered and held
//   in DONE until the consumer takes them. Only one op is in flight at a time.
//
// Configuration:
//   SEQ_ALU_MUL_EN - when defined, op 111 is an unsigned shift-add multiply that takes WIDTH
//                    cycles. When undefined, op 111 is reported as illegal through err.
//
// Parameters:
//   WIDTH     - operand/result width (>= 4)
//   ARITH_SHR - 1: SHR sign-fills, 0: SHR zero-fills
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   op and operands presented
//   in_ready   block can accept an op (IDLE only)
//   val_A      operand A
//   val_B      operand B; low $clog2(WIDTH) bits are the shift amount
//   ALU_op     000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL/illegal
//   out_valid  result and flags valid
//   out_ready  consumer takes the result
//   ALU_out    registered result
//   Z, N, V, C zero, negative, signed overflow, carry flags
//   err        illegal op, qualified by out_valid

module seq_alu #(
   parameter int WIDTH     = 16,
   parameter bit ARITH_SHR = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] val_A,
   input  logic [WIDTH-1:0] val_B,
   input  logic [2:0]       ALU_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_out,
   output logic             Z,
   output logic             N,
   output logic             V,
   output logic             C,
   output logic             err
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
`ifdef SEQ_ALU_MUL_EN
   localparam logic [2:0] OP_MUL = 3'b111;
`endif

`ifdef SEQ_ALU_MUL_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2,
      S_MUL  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;
`endif

   state_t           state_q;

   // Latched operands; a_q doubles as the shift register, b_q as the multiplier shift register.
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;   // last bit shifted out so far

   // Registered outputs.
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] alu_out_q;
   logic             z_q, n_q, v_q, c_q, err_q;

   // Single-step arithmetic on the latched operands.
   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   assign add_w = {1'b0, a_q} + {1'b0, b_q};
   // A + ~B + 1: the carry out is set exactly when there is no borrow.
   assign sub_w = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};

   logic             is_shift;
   assign is_shift = (op_q == OP_SHL) || (op_q == OP_SHR);

   // One-bit shift step.
   logic [WIDTH-1:0] shift_a_d;
   logic             shift_c_d;
   always_comb begin
      shift_a_d = a_q;
      shift_c_d = carry_q;
      if (op_q == OP_SHL) begin
         shift_a_d = {a_q[WIDTH-2:0], 1'b0};
         shift_c_d = a_q[WIDTH-1];
      end else begin
         shift_a_d = {(ARITH_SHR ? a_q[WIDTH-1] : 1'b0), a_q[WIDTH-1:1]};
         shift_c_d = a_q[0];
      end
   end

   // Final result/flags for everything that finishes in BUSY. For shifts this is only
   // used once the counter has reached zero, so a_q already holds the shifted value.
   logic [WIDTH-1:0] res_d;
   logic             v_d, c_d, err_d;
   always_comb begin
      res_d = '0;
      v_d   = 1'b0;
      c_d   = 1'b0;
      err_d = 1'b0;
      case (op_q)
         OP_ADD: begin
            res_d = add_w[WIDTH-1:0];
            c_d   = add_w[WIDTH];
            v_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            res_d = sub_w[WIDTH-1:0];
            c_d   = sub_w[WIDTH];
            v_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_AND: res_d = a_q & b_q;
         OP_OR:  res_d = a_q | b_q;
         OP_XOR: res_d = a_q ^ b_q;
         OP_SHL, OP_SHR: begin
            res_d = a_q;
            c_d   = carry_q;
         end
         default: err_d = 1'b1;   // result stays 0, so Z=1
      endcase
   end

`ifdef SEQ_ALU_MUL_EN
   // Shift-add multiply: {hi_q, b_q} is the partial product with the multiplier in the
   // low half. Each step conditionally adds A into the high half, then shifts right.
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   assign mul_sum  = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, b_q[WIDTH-1:1]};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         alu_out_q   <= '0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         v_q         <= 1'b0;
         c_q         <= 1'b0;
         err_q       <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
         hi_q        <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= val_A;
                  b_q        <= val_B;
                  op_q       <= ALU_op;
                  cnt_q      <= val_B[CW-1:0];
                  carry_q    <= 1'b0;
                  in_ready_q <= 1'b0;
                  state_q    <= S_BUSY;
`ifdef SEQ_ALU_MUL_EN
                  if (ALU_op == OP_MUL) begin
                     cnt_q   <= '0;
                     hi_q    <= '0;
                     state_q <= S_MUL;
                  end
`endif
               end
            end

            S_BUSY: begin
               if (is_shift && (cnt_q != '0)) begin
                  a_q     <= shift_a_d;
                  carry_q <= shift_c_d;
                  cnt_q   <= cnt_q - CW'(1);
               end else begin
                  alu_out_q   <= res_d;
                  z_q         <= (res_d == '0);
                  n_q         <= res_d[WIDTH-1];
                  v_q         <= v_d;
                  c_q         <= c_d;
                  err_q       <= err_d;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end

`ifdef SEQ_ALU_MUL_EN
            S_MUL: begin
               hi_q  <= mul_next[2*WIDTH-1:WIDTH];
               b_q   <= mul_next[WIDTH-1:0];
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH-1)) begin
                  alu_out_q   <= mul_next[WIDTH-1:0];
                  z_q         <= (mul_next[WIDTH-1:0] == '0);
                  n_q         <= mul_next[WIDTH-1];
                  v_q         <= |mul_next[2*WIDTH-1:WIDTH];
                  c_q         <= 1'b0;
                  err_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
`endif

            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end

            default: begin
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign ALU_out   = alu_out_q;
   assign Z         = z_q;
   assign N         = n_q;
   assign V         = v_q;
   assign C         = c_q;
   assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] val_A;
   logic [15:0] val_B;
   logic [2:0]  ALU_op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] ALU_out;
   logic        Z, N, V, C, err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] res;
      logic        z, n, v, c, err;
      logic [7:0]  lat;
   } exp_t;

   exp_t sb[$];

   seq_alu #(.WIDTH(16), .ARITH_SHR(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .val_A(val_A), .val_B(val_B), .ALU_op(ALU_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .ALU_out(ALU_out), .Z(Z), .N(N), .V(V), .C(C), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] res, input logic v, input logic c,
                               input logic e, input int lat);
      exp_t x;
      x.res = res; x.z = (res == 16'h0); x.n = res[15];
      x.v = v; x.c = c; x.err = e; x.lat = 8'(lat);
      return x;
   endfunction

   // Reference model of one op at WIDTH=16, ARITH_SHR=1.
   function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] w;
      logic [31:0] p;
      logic [15:0] r;
      int          sh;
      sh = int'(b[3:0]);
      case (op)
         3'd0: begin
            w = {1'b0, a} + {1'b0, b};
            return mk(w[15:0], (a[15] == b[15]) && (w[15] != a[15]), w[16], 1'b0, 1);
         end
         3'd1: begin
            r = a - b;
            return mk(r, (a[15] != b[15]) && (r[15] != a[15]), a >= b, 1'b0, 1);
         end
         3'd2: return mk(a & b, 1'b0, 1'b0, 1'b0, 1);
         3'd3: return mk(a | b, 1'b0, 1'b0, 1'b0, 1);
         3'd4: return mk(a ^ b, 1'b0, 1'b0, 1'b0, 1);
         3'd5: return mk(a << sh, 1'b0, (sh == 0) ? 1'b0 : a[16-sh], 1'b0, 1 + sh);
         3'd6: return mk(16'($signed(a) >>> sh), 1'b0, (sh == 0) ? 1'b0 : a[sh-1], 1'b0, 1 + sh);
         default: begin
`ifdef SEQ_ALU_MUL_EN
            p = {16'h0, a} * {16'h0, b};
            return mk(p[15:0], |p[31:16], 1'b0, 1'b0, 16);
`else
            p = 32'h0;
            return mk(p[15:0], 1'b0, 1'b0, 1'b1, 1);
`endif
         end
      endcase
   endfunction

   // Present an op just after a rising edge, push its expectation, wait for out_valid,
   // then pop and compare. Leaves the DUT holding its result in DONE.
   task automatic issue(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input exp_t e);
      int   cyc;
      exp_t x;
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      in_valid = 1'b1; ALU_op = op; val_A = a; val_B = b;
      @(posedge clk); #1;
      in_valid = 1'b0; val_A = 16'($urandom); val_B = 16'($urandom); ALU_op = 3'($urandom);
      sb.push_back(e);
      cyc = 0;
      while (!out_valid && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
      x = sb.pop_front();
      chk({tag, "_latency"}, cyc, x.lat);
      chk({tag, "_result"}, ALU_out, x.res);
      chk({tag, "_flags_zнvce"}, {Z, N, V, C, err}, {x.z, x.n, x.v, x.c, x.err});
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_drain"}, {out_valid, in_ready}, 2'b01);
   endtask

   logic [2:0]  rop;
   logic [15:0] ra, rb;
   logic [20:0] snap;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      val_A = '0; val_B = '0; ALU_op = '0;
      #12;
      chk("reset_state", {in_ready, out_valid, ALU_out, Z, N, V, C, err},
          {1'b1, 1'b0, 16'h0, 5'b0});
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue("add_ovf", 3'd0, 16'h7FFF, 16'h0001, mk(16'h8000, 1'b1, 1'b0, 1'b0, 1));
      release_out("add_ovf");
      issue("add_wrap", 3'd0, 16'hFFFF, 16'h0001, mk(16'h0000, 1'b0, 1'b1, 1'b0, 1));
      release_out("add_wrap");
      issue("sub_eq", 3'd1, 16'h0005, 16'h0005, mk(16'h0000, 1'b0, 1'b1, 1'b0, 1));
      release_out("sub_eq");
      issue("sub_ovf", 3'd1, 16'h8000, 16'h0001, mk(16'h7FFF, 1'b1, 1'b1, 1'b0, 1));
      release_out("sub_ovf");
      issue("sub_borrow", 3'd1, 16'h0001, 16'h0002, mk(16'hFFFF, 1'b0, 1'b0, 1'b0, 1));
      release_out("sub_borrow");
      issue("and", 3'd2, 16'hF0F0, 16'h3C3C, mk(16'h3030, 1'b0, 1'b0, 1'b0, 1));
      release_out("and");
      issue("or", 3'd3, 16'hF000, 16'h000F, mk(16'hF00F, 1'b0, 1'b0, 1'b0, 1));
      release_out("or");
      issue("xor", 3'd4, 16'hAAAA, 16'hAAAA, mk(16'h0000, 1'b0, 1'b0, 1'b0, 1));
      release_out("xor");
      issue("shl3", 3'd5, 16'h8001, 16'h0003, mk(16'h0008, 1'b0, 1'b0, 1'b0, 4));
      release_out("shl3");
      issue("shl_hibits", 3'd5, 16'hC000, 16'h00F1, mk(16'h8000, 1'b0, 1'b1, 1'b0, 2));
      release_out("shl_hibits");
      issue("shl0", 3'd5, 16'h1234, 16'h0010, mk(16'h1234, 1'b0, 1'b0, 1'b0, 1));
      release_out("shl0");
      issue("shr15", 3'd6, 16'h8000, 16'h000F, mk(16'hFFFF, 1'b0, 1'b0, 1'b0, 16));
      release_out("shr15");
      issue("shr1", 3'd6, 16'h0003, 16'h0001, mk(16'h0001, 1'b0, 1'b1, 1'b0, 2));
      release_out("shr1");

`ifdef SEQ_ALU_MUL_EN
      issue("op111", 3'd7, 16'h0100, 16'h0100, mk(16'h0000, 1'b1, 1'b0, 1'b0, 16));
      release_out("op111");
      issue("mul_small", 3'd7, 16'h0012, 16'h0034, mk(16'h03A8, 1'b0, 1'b0, 1'b0, 16));
      release_out("mul_small");
`else
      issue("op111", 3'd7, 16'h0100, 16'h0100, mk(16'h0000, 1'b0, 1'b0, 1'b1, 1));
      release_out("op111");
`endif

      // Backpressure: result held, no new op accepted while in DONE.
      issue("bp", 3'd0, 16'h1111, 16'h2222, mk(16'h3333, 1'b0, 1'b0, 1'b0, 1));
      snap = {ALU_out, Z, N, V, C, err};
      in_valid = 1'b1; ALU_op = 3'd1; val_A = 16'h0F0F; val_B = 16'h0001;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold", {out_valid, in_ready, ALU_out, Z, N, V, C, err}, {2'b10, snap});
      end
      in_valid = 1'b0;
      release_out("bp");
      repeat (3) @(posedge clk);
      #1;
      chk("bp_no_accept", {out_valid, in_ready}, 2'b01);

      // Reset in the middle of a long shift.
      in_valid = 1'b1; ALU_op = 3'd5; val_A = 16'hFFFF; val_B = 16'h000A;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back(model(3'd5, 16'hFFFF, 16'h000A));
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset", {in_ready, out_valid, ALU_out, Z, N, V, C, err},
          {1'b1, 1'b0, 16'h0, 5'b0});
      sb.delete();
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_idle", {out_valid, in_ready}, 2'b01);
      issue("post_reset_add", 3'd0, 16'h1234, 16'h4321, mk(16'h5555, 1'b0, 1'b0, 1'b0, 1));
      release_out("post_reset_add");

      // Model-driven ops with random operands.
      for (int i = 0; i < 10; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         issue("rand", rop, ra, rb, model(rop, ra, rb));
         release_out("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the CPU's combinational 16-bit ALU.
- Adds a valid/ready handshake on both sides, registered results, and the XOR/SHL/SHR ops.
- Shifts are iterative (one bit per cycle); an optional iterative multiply is compiled in by macro.
- Full Z/N/V/C flag set.
- Sits between the register-file read stage and writeback; the datapath controller stalls on in_ready/out_valid.

Parameters:
WIDTH, 16, operand/result width in bits; must be >= 4.
ARITH_SHR, 1, 1 = SHR is arithmetic (sign-fill); 0 = logical (zero-fill).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept an op
val_A  input  WIDTH  operand A
val_B  input  WIDTH  operand B; for shifts only the low $clog2(WIDTH) bits are the amount
ALU_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result
ALU_out  output  WIDTH  registered result
Z, N, V, C  output  1 each  zero, negative, signed overflow, carry flags
err  output  1  illegal op flag, qualified by out_valid

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; ALU_out=0; Z=N=V=C=0; err=0; internal counter=0. Takes effect immediately, including mid-operation, and discards any op in flight.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge E0, latch A, B, op and shift count. Go to BUSY, or to MUL if op=111 and the macro is enabled.
  - BUSY: performs one step per cycle.
    - ADD/SUB/AND/OR/XOR/illegal: result computed on the first BUSY cycle.
    - SHL/SHR: shifts 1 bit per cycle; counter decrements to 0. Shift amount 0 takes 1 BUSY cycle with the result equal to A.
  - MUL: see Optional Feature.
  - DONE: out_valid=1; outputs held stable until out_ready=1. Then go to IDLE at that edge (out_valid=0 and in_ready=1 on the next cycle).
- Latency: out_valid asserts after edge E0+1+k, where k = 0 for non-shift ops, k = shift amount for shifts, and k = WIDTH-1 for MUL.
- in_ready=0 in every state except IDLE; there is no overlap of ops.
- Arithmetic (all results mod 2^WIDTH):
  - ADD: C = carry out of bit WIDTH-1. V = both operand signs equal and result sign differs.
  - SUB: A-B. C = 1 when no borrow (A >= B unsigned). V = operand signs differ and result sign differs from A.
  - AND/OR/XOR: V=0, C=0.
  - SHL/SHR: C = last bit shifted out (0 if amount is 0). V=0.
- N = ALU_out[WIDTH-1] and Z = (ALU_out==0) for all ops; both are registered together with the result.
- Illegal op (111 with macro off): ALU_out=0, Z=1, N=V=C=0, err=1, latency 1. err=0 for every legal op.
- Simultaneous events:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside DONE.
  - Operand/op changes after acceptance have no effect.

Optional Feature:
SEQ_ALU_MUL_EN
- Defined: op 111 = unsigned shift-add multiply, one partial product per cycle, WIDTH cycles in the MUL state.
  - ALU_out = low WIDTH bits of the product.
  - V = 1 if the high WIDTH bits are nonzero; C=0.
  - Z/N are taken from ALU_out.
- Undefined: no MUL state or multiply logic exists; op 111 follows the illegal-op rule.

Test Plan:
1. ADD 0x7FFF+0x0001 -> ALU_out=0x8000, N=1, V=1, C=0, Z=0. out_valid exactly 1 cycle after the accept edge. ADD 0xFFFF+0x0001 -> 0x0000, Z=1, C=1, V=0.
2. SUB 0x0005-0x0005 -> 0x0000, Z=1, C=1, V=0. SUB 0x8000-0x0001 -> 0x7FFF, V=1, C=1. SUB 0x0001-0x0002 -> 0xFFFF, N=1, C=0.
3. SHL 0x8001 by 3 -> 0x0008, C=0, out_valid 4 cycles after accept. SHR (ARITH_SHR=1) 0x8000 by 15 -> 0xFFFF, N=1, C=0. SHR 0x0003 by 1 -> 0x0001, C=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> ALU_out and flags stable, in_ready=0, a new in_valid is not accepted. Raise out_ready -> out_valid=0 and in_ready=1 next cycle.
5. Reset mid-op: start SHL by 10 and assert rst_n=0 on cycle 4 -> out_valid=0, in_ready=1 and all outputs 0 without waiting for a clock edge. After release, a new ADD completes normally.
6. Op 111 with 0x0100, 0x0100:
   - Macro on: ALU_out=0x0000, V=1, Z=1, err=0, out_valid 16 cycles after accept.
   - Macro off: ALU_out=0, Z=1, err=1, latency 1.
